// File: rtl/serial_word_sender_if.sv
// Producer-to-serializer word handshake: in_data is transferred on a rising
// edge where in_valid && in_ready.
interface serial_word_sender_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  modport master (output in_data, output in_valid, input  in_ready);
  modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface

// File: rtl/serial_word_sender.sv
// Parallel-to-serial stage feeding a right shift register, LSB first, with a
// one-word holding buffer so consecutive words stream with no idle cycles.
module serial_word_sender #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  serial_word_sender_if.slave  in_if,
  output logic                 ser_out,
  output logic                 ser_enable,
  output logic                 word_done,
  output logic                 busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state,      w_state_n;
  logic [WIDTH-1:0] r_sreg,       w_sreg_n;
  logic [CNT_W-1:0] r_cnt,        w_cnt_n;
  logic [WIDTH-1:0] r_hold,       w_hold_n;
  logic             r_hold_valid, w_hold_valid_n;
  logic             r_word_done,  w_word_done_n;

  logic w_accept;
  logic w_last;

  assign w_accept = in_if.in_valid && !r_hold_valid;
  assign w_last   = (r_state == SHIFT) && (r_cnt == LAST_CNT);

  // NOTE: every next-state signal gets its hold value first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_n      = r_state;
    w_sreg_n       = r_sreg;
    w_cnt_n        = r_cnt;
    w_hold_n       = r_hold;
    w_hold_valid_n = r_hold_valid;
    w_word_done_n  = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_sreg_n  = in_if.in_data;
          w_cnt_n   = '0;
          w_state_n = SHIFT;
        end
      end

      SHIFT: begin
        w_sreg_n = r_sreg >> 1;
        w_cnt_n  = r_cnt + 1'b1;
        if (w_last) begin
          w_word_done_n = 1'b1;
          w_cnt_n       = '0;
          // A held word takes priority; in_ready is low then, so no accept can race it.
          if (r_hold_valid) begin
            w_sreg_n       = r_hold;
            w_hold_valid_n = 1'b0;
          end else if (w_accept) begin
            w_sreg_n = in_if.in_data;
          end else begin
            w_state_n = IDLE;
          end
        end else if (w_accept) begin
          w_hold_n       = in_if.in_data;
          w_hold_valid_n = 1'b1;
        end
      end

      default: w_state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  // NOTE: the data registers are reset too, so ser_out and a later held-word
  // load never expose stale contents after a mid-word reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_sreg       <= '0;
      r_cnt        <= '0;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_word_done  <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_sreg       <= w_sreg_n;
      r_cnt        <= w_cnt_n;
      r_hold       <= w_hold_n;
      r_hold_valid <= w_hold_valid_n;
      r_word_done  <= w_word_done_n;
    end
  end

  assign in_if.in_ready = !r_hold_valid;
  assign ser_enable     = (r_state == SHIFT);
  assign ser_out        = (r_state == SHIFT) && r_sreg[0];
  assign word_done      = r_word_done;
  assign busy           = (r_state == SHIFT) || r_hold_valid;

endmodule

// File: tb/tb_serial_word_sender.sv
// Directed bench for serial_word_sender: a producer queue drives the handshake
// and a behavioural right shift register captures the serial stream.
module tb_serial_word_sender;

  localparam int W = 8;

  logic clk;
  logic reset;
  logic ser_out, ser_enable, word_done, busy;
  logic [W-1:0] ds;

  serial_word_sender_if #(.WIDTH(W)) bus ();

  serial_word_sender #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_if      (bus.slave),
    .ser_out    (ser_out),
    .ser_enable (ser_enable),
    .word_done  (word_done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream right shift register, serial input enters at the MSB.
  always @(posedge clk) begin
    if (ser_enable) ds <= {ser_out, ds[W-1:1]};
  end

  typedef struct {
    logic [W-1:0] d;
    int           at;
  } item_t;

  item_t        prod_q[$];
  bit           en_log[$];
  bit           out_log[$];
  bit           rdy_log[$];
  int           done_cyc[$];
  logic [W-1:0] done_val[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs n cycles; at each falling edge: sample outputs, then drive the producer.
  task automatic run(input int n);
    bit pend = 1'b0;
    en_log.delete(); out_log.delete(); rdy_log.delete();
    done_cyc.delete(); done_val.delete();
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (pend) void'(prod_q.pop_front());
      en_log.push_back(ser_enable);
      out_log.push_back(ser_out);
      rdy_log.push_back(bus.in_ready);
      if (word_done) begin
        done_cyc.push_back(c);
        done_val.push_back(ds);
      end
      if (prod_q.size() > 0 && prod_q[0].at <= c) begin
        bus.in_valid = 1'b1;
        bus.in_data  = prod_q[0].d;
      end else begin
        bus.in_valid = 1'b0;
      end
      pend = bus.in_valid && bus.in_ready;
    end
  endtask

  function automatic logic [31:0] bits(input int first, input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v[i] = out_log[first + i];
    return v;
  endfunction

  function automatic int en_ones(input int first, input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += int'(en_log[first + i]);
    return s;
  endfunction

  function automatic int rdy_zeros();
    int s = 0;
    foreach (rdy_log[i]) s += int'(!rdy_log[i]);
    return s;
  endfunction

  initial begin
    reset        = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h77;
    ds           = '0;

    // Reset held with in_valid asserted.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("rst_en",    ser_enable,   0);
      check("rst_out",   ser_out,      0);
      check("rst_done",  word_done,    0);
      check("rst_busy",  busy,         0);
      check("rst_ready", bus.in_ready, 1);
    end
    bus.in_valid = 1'b0;
    reset        = 1'b1;
    @(negedge clk);
    check("rst_noacc_busy", busy,       0);
    check("rst_noacc_en",   ser_enable, 0);

    // Single word.
    prod_q.push_back('{d: 8'hD6, at: 0});
    run(12);
    check("single_bits",    bits(1, 8),      32'hD6);
    check("single_en",      en_ones(1, 8),   8);
    check("single_en_off",  en_log[9],       0);
    check("single_n_done",  done_cyc.size(), 1);
    check("single_done_at", done_cyc[0],     9);
    check("single_ds",      done_val[0],     32'hD6);

    // Back-to-back via the holding buffer.
    prod_q.push_back('{d: 8'hA5, at: 0});
    prod_q.push_back('{d: 8'h3C, at: 0});
    run(20);
    check("b2b_ready_held", rdy_log[2],       0);
    check("b2b_en",         en_ones(1, 16),   16);
    check("b2b_en_off",     en_log[17],       0);
    check("b2b_bits",       bits(1, 16),      32'h3CA5);
    check("b2b_n_done",     done_cyc.size(),  2);
    check("b2b_done0_at",   done_cyc[0],      9);
    check("b2b_done1_at",   done_cyc[1],      17);
    check("b2b_ds0",        done_val[0],      32'hA5);
    check("b2b_ds1",        done_val[1],      32'h3C);

    // Accept exactly on the last-bit edge, hold empty.
    prod_q.push_back('{d: 8'h01, at: 0});
    prod_q.push_back('{d: 8'hFF, at: 8});
    run(20);
    check("lbe_bits",     bits(1, 16),     32'hFF01);
    check("lbe_en",       en_ones(1, 16),  16);
    check("lbe_ready",    rdy_log[9],      1);
    check("lbe_n_done",   done_cyc.size(), 2);
    check("lbe_done1_at", done_cyc[1],     17);
    check("lbe_ds1",      done_val[1],     32'hFF);

    // Backpressure with three words queued.
    prod_q.push_back('{d: 8'h11, at: 0});
    prod_q.push_back('{d: 8'h22, at: 0});
    prod_q.push_back('{d: 8'h33, at: 0});
    run(30);
    check("bp_ready_zeros", rdy_zeros(),     14);
    check("bp_ready_gap",   rdy_log[9],      1);
    check("bp_en",          en_ones(1, 24),  24);
    check("bp_en_off",      en_log[25],      0);
    check("bp_n_done",      done_cyc.size(), 3);
    check("bp_done2_at",    done_cyc[2],     25);
    check("bp_ds0",         done_val[0],     32'h11);
    check("bp_ds1",         done_val[1],     32'h22);
    check("bp_ds2",         done_val[2],     32'h33);
    check("bp_drained",     prod_q.size(),   0);

    // Reset after three bits of 0x5A.
    prod_q.push_back('{d: 8'h5A, at: 0});
    run(4);
    check("mid_bits", bits(1, 3), 32'h2);
    reset = 1'b0;
    #1;
    check("mid_rst_en",    ser_enable,   0);
    check("mid_rst_out",   ser_out,      0);
    check("mid_rst_busy",  busy,         0);
    check("mid_rst_ready", bus.in_ready, 1);
    check("mid_rst_done",  word_done,    0);
    @(negedge clk);
    reset = 1'b1;
    run(10);
    check("mid_no_done", done_cyc.size(), 0);
    check("mid_idle_en", en_ones(0, 10),  0);

    prod_q.push_back('{d: 8'h81, at: 0});
    run(12);
    check("post_bits",    bits(1, 8),      32'h81);
    check("post_n_done",  done_cyc.size(), 1);
    check("post_done_at", done_cyc[0],     9);
    check("post_ds",      done_val[0],     32'h81);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_word_sender.md
Name: serial_word_sender

Overview:
Parallel-to-serial stage that sits directly upstream of the right shift register. It accepts WIDTH-bit words over a valid/ready handshake and drives the register's serial input and shift enable, one bit per clock. Bits go out LSB first, so that after WIDTH shifts the downstream register's parallel output equals the accepted word. A one-word holding buffer lets a stream of words go out back-to-back with no idle cycles.

Parameters:
WIDTH, 8, word width in bits and number of shifts per word; must be >= 2.

Ports:
clk  input  1  rising-edge clock shared with the downstream shift register.
reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
in_data  input  WIDTH  word to serialize.
in_valid  input  1  in_data is valid this cycle.
in_ready  output  1  block can accept a word this cycle.
ser_out  output  1  serial bit; connects to the shift register's serial input.
ser_enable  output  1  shift enable; connects to the shift register's enable.
word_done  output  1  one-cycle pulse: the last bit of a word has just been shifted in downstream.
busy  output  1  shifter is active or the holding buffer is occupied.

Behaviour:
- State: shift register sreg[WIDTH], bit counter cnt[$clog2(WIDTH)], active flag, holding buffer hold[WIDTH], hold_valid flag.
- All outputs are registered or derived only from registered state. There is no combinational path from in_valid to any output.
- Reset (reset=0, asynchronous):
  - active=0, hold_valid=0, cnt=0, sreg=0, hold=0.
  - ser_out=0, ser_enable=0, word_done=0, busy=0, in_ready=1 while reset is low.
- in_ready = !hold_valid.
- A word is accepted on a rising edge where in_valid && in_ready.
- States:
  - IDLE (active=0): ser_enable=0 and ser_out=0.
    - If a word is accepted: load sreg=in_data, cnt=0, active=1.
    - From the next cycle: ser_enable=1 and ser_out=in_data[0].
  - SHIFT (active=1): ser_enable=1 and ser_out=sreg[0].
    - Each edge: sreg shifts right by 1 and cnt increments.
    - The edge at which cnt==WIDTH-1 is the last-bit edge.
- Accept while SHIFT and not on the last-bit edge: the word goes to hold and hold_valid becomes 1.
- Last-bit edge, three cases:
  - hold_valid=1: load sreg=hold, clear hold_valid, cnt=0, stay in SHIFT.
  - hold_valid=0 and a word is accepted on the same edge: load sreg=in_data directly, cnt=0, stay in SHIFT.
  - Otherwise: go to IDLE.
  - In every case word_done=1 for the cycle that follows the edge. That is the cycle in which the downstream register holds the complete word.
- Throughput: one word per WIDTH cycles under continuous supply. ser_enable stays high across word boundaries.
- Latency: the first bit appears in the cycle after acceptance. word_done follows acceptance by WIDTH cycles when the shifter was idle.
- When hold is full, in_valid is ignored. The producer must hold in_data and in_valid until it sees in_ready.
- busy = active || hold_valid.
- Reset mid-word: the partial word and the held word are discarded. No word_done is produced. Outputs take their reset values at once.
- An in_valid pulse shorter than one clock edge has no effect.

Test Plan:
- Reset: drive reset=0 for 2 cycles with in_valid=1 -> ser_enable=0, ser_out=0, word_done=0, busy=0, in_ready=1, and no word is accepted.
- Single word: accept 8'hD6 while idle -> over 8 consecutive cycles ser_enable=1 and ser_out=0,1,1,0,1,0,1,1. word_done=1 in the following cycle together with ser_enable=0. A connected right shift register then reads 8'b11010110.
- Back-to-back: present 8'hA5 then 8'h3C on consecutive cycles -> both accepted, and in_ready=0 while 8'h3C sits in hold.
  - ser_enable is high for 16 contiguous cycles.
  - word_done pulses after cycle 8 (downstream reads 8'hA5) and after cycle 16 (downstream reads 8'h3C).
- Last-bit-edge accept: with hold empty, present 8'hFF exactly at the last-bit edge of 8'h01 -> no gap, and the ser_out stream is 1,0,0,0,0,0,0,0,1,1,1,1,1,1,1,1.
- Backpressure: keep in_valid=1 with 3 words queued at the producer -> in_ready toggles so that exactly one word sits in hold. No word is lost or duplicated, which is checked by comparing the downstream values captured at each word_done.
- Mid-word reset: assert reset=0 after 3 bits of 8'h5A -> all outputs reset immediately and no word_done occurs. After release, accepting 8'h81 produces correct output starting from bit 0.
